// File: rtl/mem_access_pkg.sv
// ----------------------------------------------------------------------------
// mem_access_pkg: shared size encodings and FSM states | rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package mem_access_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    RMW_RD = 3'd2,
    WRITE  = 3'd3,
    RESP   = 3'd4
  } state_t;

endpackage

`default_nettype wire

// File: rtl/mem_lane_align.sv
// ----------------------------------------------------------------------------
// mem_lane_align: little-endian load extract/extend and store lane merge | rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mem_lane_align
  import mem_access_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [31:0] rword,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_sign;

  always_comb begin
    w_byte    = rword[{addr_lo, 3'b000} +: 8];
    w_half    = rword[{addr_lo[1], 4'b0000} +: 16];
    w_sign    = 1'b0;
    load_data = rword;
    merged    = wdata;
    case (size)
      SZ_BYTE: begin
        w_sign    = ~is_unsigned & w_byte[7];
        load_data = {{24{w_sign}}, w_byte};
        merged    = rword;
        merged[{addr_lo, 3'b000} +: 8] = wdata[7:0];
      end
      SZ_HALF: begin
        w_sign    = ~is_unsigned & w_half[15];
        load_data = {{16{w_sign}}, w_half};
        merged    = rword;
        merged[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
      end
      default: begin
        load_data = rword;
        merged    = wdata;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mem_access_unit.sv
// ----------------------------------------------------------------------------
// mem_access_unit: load/store initiator for a word-organised data memory | rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int MEM_SIZE = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] mem_address,
  output logic [31:0] mem_writeData,
  output logic        mem_memWrite,
  output logic        mem_memRead,
  input  logic [31:0] mem_readData
);

  state_t      r_state;
  state_t      w_next;
  logic [1:0]  r_size;
  logic        r_unsigned;
  logic [1:0]  r_addr_lo;
  logic [31:0] r_wword;
  logic        w_accept;
  logic        w_err;
  logic [31:0] w_load;
  logic [31:0] w_merged;

  assign req_ready = rst_n && (r_state == IDLE);
  assign w_accept  = req_valid && req_ready;

  always_comb begin
    w_err = 1'b0;
    if (req_size == 2'b11)
      w_err = 1'b1;
    else if (req_size == SZ_HALF && req_addr[0])
      w_err = 1'b1;
    else if (req_size == SZ_WORD && req_addr[1:0] != 2'b00)
      w_err = 1'b1;
    else if ({2'b00, req_addr[31:2]} >= 32'(MEM_SIZE))
      w_err = 1'b1;
  end

  always_comb begin
    w_next        = r_state;
    mem_memRead   = 1'b0;
    mem_memWrite  = 1'b0;
    mem_writeData = 32'h0;
    rsp_valid     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_err)                    w_next = RESP;
          else if (!req_write)          w_next = LOAD;
          else if (req_size == SZ_WORD) w_next = WRITE;
          else                          w_next = RMW_RD;
        end
      end
      LOAD: begin
        mem_memRead = 1'b1;
        w_next      = RESP;
      end
      RMW_RD: begin
        mem_memRead = 1'b1;
        w_next      = WRITE;
      end
      WRITE: begin
        mem_memWrite  = 1'b1;
        mem_writeData = r_wword;
        w_next        = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // r_wword carries the store word: raw data for word stores, merged word after RMW_RD
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_size      <= 2'b00;
      r_unsigned  <= 1'b0;
      r_addr_lo   <= 2'b00;
      r_wword     <= 32'h0;
      mem_address <= 32'h0;
      rsp_rdata   <= 32'h0;
      rsp_err     <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_size      <= req_size;
            r_unsigned  <= req_unsigned;
            r_addr_lo   <= req_addr[1:0];
            r_wword     <= req_wdata;
            mem_address <= {2'b00, req_addr[31:2]};
            rsp_err     <= w_err;
            rsp_rdata   <= 32'h0;
          end
        end
        LOAD:    rsp_rdata <= w_load;
        RMW_RD:  r_wword   <= w_merged;
        default: ;
      endcase
    end
  end

  mem_lane_align u_align (
    .addr_lo     (r_addr_lo),
    .size        (r_size),
    .is_unsigned (r_unsigned),
    .rword       (mem_readData),
    .wdata       (r_wword),
    .load_data   (w_load),
    .merged      (w_merged)
  );

endmodule

`default_nettype wire

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Initiator side of the data-memory port: accepts load/store requests from the datapath over a valid/ready handshake and drives the word-organised data memory's address/writeData/memWrite/memRead/readData interface.
- Supports byte, halfword and word accesses, signed or unsigned.
- Sub-word stores are done as read-modify-write.
- Checks alignment and address range, then returns one response per request.

Parameters:
- MEM_SIZE, 64, number of 32-bit words in the attached data memory. Word index range is 0..MEM_SIZE-1.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data. Byte/half data is taken from the low bits.
- rsp_valid  out  1  response present; held until accepted.
- rsp_ready  in  1  consumer accepts the response.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  1  misaligned, illegal size, or out of range.
- mem_address  out  32  word index, equal to req_addr[31:2] zero-extended.
- mem_writeData  out  32  word to write.
- mem_memWrite  out  1  write strobe; memory writes at the clk edge.
- mem_memRead  out  1  read enable.
- mem_readData  in  32  combinational read data. High-Z when mem_memRead=0, so it is never sampled then.

Behaviour:
- Reset (rst_n low, takes effect immediately):
  - State goes to IDLE.
  - rsp_valid, rsp_err, rsp_rdata, mem_memWrite, mem_memRead, mem_writeData and mem_address are all 0.
  - req_ready is 0 while rst_n is low.
  - A reset in any state aborts the operation. No memory write is issued afterwards.
  - A write strobe already sampled at an earlier edge is not undone.
- States: IDLE, LOAD, RMW_RD, WRITE, RESP.
- IDLE:
  - req_ready = 1. Accept when req_valid and req_ready at a rising edge.
  - On accept, all request fields are captured into registers.
  - Errors are decoded from the captured request, in this priority:
    - size 11 → error;
    - half with addr[0]=1 → error;
    - word with addr[1:0]≠0 → error;
    - addr[31:2] ≥ MEM_SIZE → error.
  - Next state: error → RESP with rsp_err=1 and no memory access. Load → LOAD. Word store → WRITE. Byte/half store → RMW_RD.
- LOAD: mem_memRead=1. Select the byte lane by addr[1:0] (little-endian) or the half lane by addr[1]. Extend per req_unsigned, register into rsp_rdata. Next state RESP.
- RMW_RD:
  - mem_memRead=1.
  - Register the merged word: the read word with the addressed lane(s) replaced by req_wdata[7:0] or req_wdata[15:0].
  - Next state WRITE.
- WRITE: mem_memWrite=1 for exactly one cycle. mem_writeData = req_wdata (word store) or the merged word. Next state RESP.
- RESP:
  - rsp_valid=1, with rsp_rdata and rsp_err stable.
  - When rsp_ready=1 at the edge, go to IDLE. The next request can only be accepted in the following cycle (no back-to-back overlap).
- mem_memRead and mem_memWrite are never asserted together. Both are 0 in IDLE and RESP.
- mem_address holds the captured word index from accept until the return to IDLE.
- Latency from accept edge to the first rsp_valid cycle: load 2, word store 2, sub-word store 3, error 1.
- Inputs on the req_* ports are ignored outside IDLE.

Decomposition:
- Package mem_access_pkg: the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and the state enum.
- Sub-module mem_lane_align: purely combinational. Performs load extract/extend and store lane merge, driven by addr[1:0], size, unsigned and the two words.
- The FSM and all registers stay in the top module.

Test Plan:
- Word store then load: store 0xDEADBEEF to addr 0x10 → mem_memWrite for one cycle at index 4, rsp_err=0. Then load word from 0x10 → rsp_rdata=0xDEADBEEF two edges after accept.
- Byte RMW: memory word 4 = 0x11223344; store byte 0xAA to 0x12 → memory becomes 0x11AA3344. Load signed byte from 0x12 → rsp_rdata=0xFFFFFFAA; unsigned → 0x000000AA.
- Half: store half 0x8001 to 0x16 → word 5 upper half = 0x8001. Signed load half from 0x16 → 0xFFFF8001.
- Errors:
  - Load word from 0x13 → rsp_err=1 in the first cycle after accept, mem_memRead never asserted.
  - Size 11 → rsp_err=1.
  - Address 4*MEM_SIZE (0x100) → rsp_err=1, no write.
- Backpressure: hold rsp_ready=0 for 5 cycles → rsp_valid and rsp_rdata stay stable, req_ready stays 0, a new req_valid is not accepted until one cycle after rsp_ready.
- Reset mid-RMW: assert rst_n low during RMW_RD → outputs go to 0 immediately, memory word is unchanged, req_ready=1 in the first cycle after release.
